// File: rtl/median_filter_param.sv
// Streaming 3x3 median filter with two line buffers, a 3-stage sorting pipeline and self-flush of the last row.
// Modes: 0 bypass, 1/3 median, 2 hole-fill (median only where the centre equals HOLE_VAL).
module median_filter_param #(
    parameter int DISP_W   = 9,
    parameter int MAX_W    = 1920,
    parameter int ADDR_W   = 11,
    parameter int HOLE_VAL = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clken,
    input  logic              enable,
    input  logic [1:0]        mode,
    input  logic [ADDR_W-1:0] width,
    input  logic [10:0]       height,
    input  logic [DISP_W-1:0] disp_in,
    input  logic              valid_in,
    output logic [DISP_W-1:0] disp_out,
    output logic              valid_out,
    output logic              flag,
    output logic              err
);
    typedef logic [DISP_W-1:0] pix_t;
    typedef enum logic [2:0] {S_IDLE, S_FILL, S_RUN, S_EOL, S_FLUSH, S_DONE} state_t;

    function automatic pix_t max2(input pix_t a, input pix_t b);
        return (a > b) ? a : b;
    endfunction

    function automatic pix_t min2(input pix_t a, input pix_t b);
        return (a < b) ? a : b;
    endfunction

    function automatic pix_t med3(input pix_t a, input pix_t b, input pix_t c);
        return max2(min2(a, b), min2(max2(a, b), c));
    endfunction

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] col_q, col_d, width_q, width_d, last_col;
    logic [10:0]       row_q, row_d, height_q, height_d;
    logic [1:0]        mode_q, mode_d;
    logic              err_q, err_d;
    // Window columns: index 0 = row r-2, 1 = row r-1, 2 = row r
    pix_t [2:0]        col_a_q, col_a_d, col_b_q, col_b_d, new_col;
    pix_t [2:0]        win [3];
    pix_t              rd_top, rd_mid, centre;
    logic              accept, trig, border, last;

    pix_t [2:0]        s1_lo_q, s1_lo_d, s1_md_q, s1_md_d, s1_hi_q, s1_hi_d;
    pix_t              s1_ctr_q, s1_ctr_d;
    logic              s1_pass_q, s1_pass_d, s1_vld_q, s1_vld_d, s1_last_q, s1_last_d;
    pix_t              s2_lo_q, s2_lo_d, s2_md_q, s2_md_d, s2_hi_q, s2_hi_d, s2_ctr_q, s2_ctr_d;
    logic              s2_pass_q, s2_pass_d, s2_vld_q, s2_vld_d, s2_last_q, s2_last_d;
    pix_t              disp_out_q, disp_out_d;
    logic              valid_out_q, valid_out_d, last_out_q, last_out_d, flag_q, flag_d;

    pix_t lb0_mem [MAX_W];
    pix_t lb1_mem [MAX_W];

    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        row_d    = row_q;
        width_d  = width_q;
        height_d = height_q;
        mode_d   = mode_q;
        err_d    = err_q;
        col_a_d  = col_a_q;
        col_b_d  = col_b_q;
        accept   = 1'b0;
        trig     = 1'b0;
        border   = 1'b0;
        last     = 1'b0;
        centre   = col_a_q[1];
        rd_top   = lb1_mem[col_q];
        rd_mid   = lb0_mem[col_q];
        new_col  = {disp_in, rd_mid, rd_top};
        last_col = width_q - ADDR_W'(1);
        flag_d   = valid_out_q & last_out_q;

        case (state_q)
            S_IDLE: begin
                if (valid_in && enable) begin
                    accept   = 1'b1;
                    width_d  = width;
                    height_d = height;
                    mode_d   = mode;
                    err_d    = 1'b0;
                    row_d    = '0;
                    col_d    = ADDR_W'(1);
                    state_d  = S_FILL;
                end
            end
            S_FILL: begin
                if (valid_in) begin
                    accept = 1'b1;
                    if (col_q == last_col) begin
                        col_d   = '0;
                        row_d   = 11'd1;
                        state_d = S_RUN;
                    end else begin
                        col_d = col_q + ADDR_W'(1);
                    end
                end
            end
            S_RUN: begin
                if (valid_in) begin
                    accept = 1'b1;
                    // Accepting column c completes the window centred on (r-1, c-1)
                    if (col_q != '0) begin
                        trig   = 1'b1;
                        border = (row_q == 11'd1) || (col_q == ADDR_W'(1));
                    end
                    if (col_q == last_col) begin
                        col_d   = '0;
                        state_d = S_EOL;
                    end else begin
                        col_d = col_q + ADDR_W'(1);
                    end
                end
            end
            S_EOL: begin
                trig   = 1'b1;
                border = 1'b1;
                err_d  = err_q | valid_in;
                if (row_q == height_q - 11'd1) begin
                    col_d   = '0;
                    state_d = S_FLUSH;
                end else begin
                    row_d   = row_q + 11'd1;
                    state_d = S_RUN;
                end
            end
            S_FLUSH: begin
                // Bottom row is all border: stream it straight out of the newest line buffer
                trig   = 1'b1;
                border = 1'b1;
                centre = rd_mid;
                err_d  = err_q | valid_in;
                if (col_q == last_col) begin
                    last    = 1'b1;
                    col_d   = '0;
                    state_d = S_DONE;
                end else begin
                    col_d = col_q + ADDR_W'(1);
                end
            end
            S_DONE: begin
                if (flag_d) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (!enable) begin
            state_d = S_IDLE;
            col_d   = '0;
            row_d   = '0;
            accept  = 1'b0;
            trig    = 1'b0;
        end

        if (accept) begin
            col_b_d = col_a_q;
            col_a_d = new_col;
        end

        win[0] = col_b_q;
        win[1] = col_a_q;
        win[2] = new_col;
        for (int k = 0; k < 3; k++) begin
            s1_lo_d[k] = min2(min2(win[k][0], win[k][1]), win[k][2]);
            s1_md_d[k] = med3(win[k][0], win[k][1], win[k][2]);
            s1_hi_d[k] = max2(max2(win[k][0], win[k][1]), win[k][2]);
        end
        s1_ctr_d  = centre;
        s1_pass_d = border || (mode_q == 2'd0) || ((mode_q == 2'd2) && (centre != pix_t'(HOLE_VAL)));
        s1_vld_d  = trig;
        s1_last_d = last;

        s2_lo_d   = max2(max2(s1_lo_q[0], s1_lo_q[1]), s1_lo_q[2]);
        s2_md_d   = med3(s1_md_q[0], s1_md_q[1], s1_md_q[2]);
        s2_hi_d   = min2(min2(s1_hi_q[0], s1_hi_q[1]), s1_hi_q[2]);
        s2_ctr_d  = s1_ctr_q;
        s2_pass_d = s1_pass_q;
        s2_vld_d  = s1_vld_q;
        s2_last_d = s1_last_q;

        valid_out_d = s2_vld_q;
        last_out_d  = s2_vld_q & s2_last_q;
        disp_out_d  = disp_out_q;
        if (s2_vld_q) disp_out_d = s2_pass_q ? s2_ctr_q : med3(s2_lo_q, s2_md_q, s2_hi_q);

        if (!enable) begin
            s1_vld_d    = 1'b0;
            s2_vld_d    = 1'b0;
            valid_out_d = 1'b0;
            last_out_d  = 1'b0;
            flag_d      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (clken && accept) begin
            lb0_mem[col_q] <= disp_in;
            lb1_mem[col_q] <= rd_mid;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            col_q       <= '0;
            row_q       <= '0;
            width_q     <= '0;
            height_q    <= '0;
            mode_q      <= '0;
            err_q       <= 1'b0;
            col_a_q     <= '0;
            col_b_q     <= '0;
            s1_lo_q     <= '0;
            s1_md_q     <= '0;
            s1_hi_q     <= '0;
            s1_ctr_q    <= '0;
            s1_pass_q   <= 1'b0;
            s1_vld_q    <= 1'b0;
            s1_last_q   <= 1'b0;
            s2_lo_q     <= '0;
            s2_md_q     <= '0;
            s2_hi_q     <= '0;
            s2_ctr_q    <= '0;
            s2_pass_q   <= 1'b0;
            s2_vld_q    <= 1'b0;
            s2_last_q   <= 1'b0;
            disp_out_q  <= '0;
            valid_out_q <= 1'b0;
            last_out_q  <= 1'b0;
            flag_q      <= 1'b0;
        end else if (clken) begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            width_q     <= width_d;
            height_q    <= height_d;
            mode_q      <= mode_d;
            err_q       <= err_d;
            col_a_q     <= col_a_d;
            col_b_q     <= col_b_d;
            s1_lo_q     <= s1_lo_d;
            s1_md_q     <= s1_md_d;
            s1_hi_q     <= s1_hi_d;
            s1_ctr_q    <= s1_ctr_d;
            s1_pass_q   <= s1_pass_d;
            s1_vld_q    <= s1_vld_d;
            s1_last_q   <= s1_last_d;
            s2_lo_q     <= s2_lo_d;
            s2_md_q     <= s2_md_d;
            s2_hi_q     <= s2_hi_d;
            s2_ctr_q    <= s2_ctr_d;
            s2_pass_q   <= s2_pass_d;
            s2_vld_q    <= s2_vld_d;
            s2_last_q   <= s2_last_d;
            disp_out_q  <= disp_out_d;
            valid_out_q <= valid_out_d;
            last_out_q  <= last_out_d;
            flag_q      <= flag_d;
        end
    end

    assign disp_out  = disp_out_q;
    assign valid_out = valid_out_q;
    assign flag      = flag_q;
    assign err       = err_q;
endmodule

// File: tb/tb_median_filter_param.sv
// Directed bench for median_filter_param: small frames with hand-computed filtered results.
module tb_median_filter_param;
    logic        clk = 1'b0;
    logic        rst, clken, enable, valid_in;
    logic [1:0]  mode;
    logic [10:0] width, height;
    logic [8:0]  disp_in, disp_out;
    logic        valid_out, flag, err;

    int n_chk = 0, n_fail = 0;
    int cyc = 0, flag_cnt = 0, flag_cyc = 0, last_v_cyc = 0, gap_g = 0;
    bit ck_prev = 1'b0;
    logic [8:0] out_q[$];
    logic [8:0] in_pix [32];

    // 4x3 frame and its median result (interior (1,1) -> 5, (1,2) -> 8)
    localparam logic [8:0] FA     [12] = '{1, 2, 3, 14, 5, 9, 12, 8, 7, 11, 2, 1};
    localparam logic [8:0] FA_MED [12] = '{1, 2, 3, 14, 5, 5, 8, 8, 7, 11, 2, 1};
    // 5x3 frame: hole at (1,1); medians of the interior are 4, 5, 6
    localparam logic [8:0] FB      [15] = '{3, 3, 4, 6, 6, 4, 0, 9, 7, 8, 5, 5, 5, 2, 1};
    localparam logic [8:0] FB_MED  [15] = '{3, 3, 4, 6, 6, 4, 4, 5, 6, 8, 5, 5, 5, 2, 1};
    localparam logic [8:0] FB_HOLE [15] = '{3, 3, 4, 6, 6, 4, 4, 9, 7, 8, 5, 5, 5, 2, 1};

    median_filter_param dut (
        .clk(clk), .rst(rst), .clken(clken), .enable(enable), .mode(mode),
        .width(width), .height(height), .disp_in(disp_in), .valid_in(valid_in),
        .disp_out(disp_out), .valid_out(valid_out), .flag(flag), .err(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        ck_prev <= clken;
    end

    always @(negedge clk) begin
        if (!rst && ck_prev) begin
            if (valid_out) begin
                out_q.push_back(disp_out);
                last_v_cyc = cyc;
            end
            if (flag) begin
                flag_cnt++;
                flag_cyc = cyc;
            end
        end
    end

    task automatic drive_px(input logic v, input logic [8:0] d);
        @(negedge clk);
        clken = 1'b1; valid_in = v; disp_in = d;
        for (int i = 0; i < gap_g; i++) begin
            @(negedge clk);
            clken = 1'b0; valid_in = 1'b1; disp_in = 9'h1AB;
        end
    endtask

    task automatic send_frame(input int w, input int h, input logic [1:0] m, input int inj_row);
        int f0;
        f0 = flag_cnt;
        width = 11'(w); height = 11'(h); mode = m; enable = 1'b1;
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) drive_px(1'b1, in_pix[r*w+c]);
            drive_px(r == inj_row, 9'd99);
        end
        for (int i = 0; i < 200 && flag_cnt == f0; i++) drive_px(1'b0, 9'd0);
        repeat (4) drive_px(1'b0, 9'd0);
    endtask

    task automatic test_reset();
        rst = 1'b1; clken = 1'b1; enable = 1'b0; valid_in = 1'b0; disp_in = '0;
        mode = '0; width = 11'd4; height = 11'd3;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_chk++; if (disp_out !== 9'd0) begin n_fail++; $display("FAIL reset_disp_out: got %0d expected 0", disp_out); end
        n_chk++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_valid_out: got %b expected 0", valid_out); end
        n_chk++; if (flag !== 1'b0) begin n_fail++; $display("FAIL reset_flag: got %b expected 0", flag); end
        n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", err); end
    endtask

    task automatic test_const();
        int base, f0;
        for (int i = 0; i < 12; i++) in_pix[i] = 9'd7;
        base = out_q.size(); f0 = flag_cnt;
        send_frame(4, 3, 2'd1, -1);
        n_chk++; if (out_q.size() - base != 12) begin n_fail++; $display("FAIL const_count: got %0d expected 12", out_q.size() - base); end
        for (int i = 0; i < 12 && base + i < out_q.size(); i++) begin
            n_chk++; if (out_q[base+i] !== 9'd7) begin n_fail++; $display("FAIL const_val[%0d]: got %0d expected 7", i, out_q[base+i]); end
        end
        n_chk++; if (flag_cnt != f0 + 1) begin n_fail++; $display("FAIL const_flag_count: got %0d expected %0d", flag_cnt - f0, 1); end
        n_chk++; if (flag_cyc != last_v_cyc + 1) begin n_fail++; $display("FAIL const_flag_timing: flag at %0d, last valid at %0d, expected one cycle later", flag_cyc, last_v_cyc); end
        n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL const_err: got %b expected 0", err); end
    endtask

    task automatic test_spike();
        int base;
        for (int i = 0; i < 15; i++) in_pix[i] = 9'd10;
        in_pix[7] = 9'd200;
        base = out_q.size();
        send_frame(5, 3, 2'd1, -1);
        n_chk++; if (out_q.size() - base != 15) begin n_fail++; $display("FAIL spike_count: got %0d expected 15", out_q.size() - base); end
        for (int i = 0; i < 15 && base + i < out_q.size(); i++) begin
            n_chk++; if (out_q[base+i] !== 9'd10) begin n_fail++; $display("FAIL spike_val[%0d]: got %0d expected 10", i, out_q[base+i]); end
        end
    endtask

    task automatic test_modes();
        int base;
        logic [8:0] e;
        for (int m = 0; m < 4; m++) begin
            for (int i = 0; i < 15; i++) in_pix[i] = FB[i];
            base = out_q.size();
            send_frame(5, 3, 2'(m), -1);
            n_chk++; if (out_q.size() - base != 15) begin n_fail++; $display("FAIL mode%0d_count: got %0d expected 15", m, out_q.size() - base); end
            for (int i = 0; i < 15 && base + i < out_q.size(); i++) begin
                e = (m == 0) ? FB[i] : (m == 2) ? FB_HOLE[i] : FB_MED[i];
                n_chk++; if (out_q[base+i] !== e) begin n_fail++; $display("FAIL mode%0d_val[%0d]: got %0d expected %0d", m, i, out_q[base+i], e); end
            end
        end
    endtask

    task automatic test_err();
        int base;
        for (int i = 0; i < 12; i++) in_pix[i] = 9'(i + 1);
        base = out_q.size();
        send_frame(4, 3, 2'd0, 1);
        n_chk++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_set: got %b expected 1", err); end
        n_chk++; if (out_q.size() - base != 12) begin n_fail++; $display("FAIL err_count: got %0d expected 12", out_q.size() - base); end
        for (int i = 0; i < 12 && base + i < out_q.size(); i++) begin
            n_chk++; if (out_q[base+i] !== 9'(i + 1)) begin n_fail++; $display("FAIL err_val[%0d]: got %0d expected %0d", i, out_q[base+i], i + 1); end
        end
    endtask

    task automatic test_abort();
        int base, f0;
        for (int i = 0; i < 12; i++) in_pix[i] = FA[i];
        base = out_q.size(); f0 = flag_cnt;
        width = 11'd4; height = 11'd3; mode = 2'd1; enable = 1'b1;
        for (int c = 0; c < 4; c++) drive_px(1'b1, in_pix[c]);
        drive_px(1'b0, 9'd0);
        drive_px(1'b1, in_pix[4]);
        drive_px(1'b1, in_pix[5]);
        @(negedge clk);
        enable = 1'b0; valid_in = 1'b0; clken = 1'b1;
        repeat (10) @(negedge clk);
        n_chk++; if (out_q.size() != base) begin n_fail++; $display("FAIL abort_outputs: got %0d expected 0", out_q.size() - base); end
        n_chk++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL abort_valid_out: got %b expected 0", valid_out); end
        n_chk++; if (flag_cnt != f0) begin n_fail++; $display("FAIL abort_flag: got %0d pulses expected 0", flag_cnt - f0); end
        base = out_q.size();
        send_frame(4, 3, 2'd1, -1);
        n_chk++; if (out_q.size() - base != 12) begin n_fail++; $display("FAIL after_abort_count: got %0d expected 12", out_q.size() - base); end
        for (int i = 0; i < 12 && base + i < out_q.size(); i++) begin
            n_chk++; if (out_q[base+i] !== FA_MED[i]) begin n_fail++; $display("FAIL after_abort_val[%0d]: got %0d expected %0d", i, out_q[base+i], FA_MED[i]); end
        end
        n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL err_cleared: got %b expected 0", err); end
    endtask

    task automatic test_clken();
        int base;
        for (int i = 0; i < 12; i++) in_pix[i] = FA[i];
        base = out_q.size();
        gap_g = 2;
        send_frame(4, 3, 2'd3, -1);
        gap_g = 0;
        n_chk++; if (out_q.size() - base != 12) begin n_fail++; $display("FAIL clken_count: got %0d expected 12", out_q.size() - base); end
        for (int i = 0; i < 12 && base + i < out_q.size(); i++) begin
            n_chk++; if (out_q[base+i] !== FA_MED[i]) begin n_fail++; $display("FAIL clken_val[%0d]: got %0d expected %0d", i, out_q[base+i], FA_MED[i]); end
        end
    endtask

    task automatic test_min_size();
        int base, f0;
        for (int i = 0; i < 6; i++) in_pix[i] = 9'(20 + 10 * i);
        base = out_q.size(); f0 = flag_cnt;
        send_frame(3, 2, 2'd1, -1);
        n_chk++; if (out_q.size() - base != 6) begin n_fail++; $display("FAIL min_count: got %0d expected 6", out_q.size() - base); end
        for (int i = 0; i < 6 && base + i < out_q.size(); i++) begin
            n_chk++; if (out_q[base+i] !== 9'(20 + 10 * i)) begin n_fail++; $display("FAIL min_val[%0d]: got %0d expected %0d", i, out_q[base+i], 20 + 10 * i); end
        end
        n_chk++; if (flag_cnt != f0 + 1) begin n_fail++; $display("FAIL min_flag: got %0d pulses expected 1", flag_cnt - f0); end
    endtask

    initial begin
        test_reset();
        test_const();
        test_spike();
        test_modes();
        test_err();
        test_abort();
        test_clken();
        test_min_size();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
